// File: rtl/fpu_fp16_to_int.sv
// FP16 -> signed INTW-bit integer converter: iterative alignment, RNE rounding, saturation.
// Optional `define FPU_CVT_RTZ_EN adds an rtz input selecting truncation toward zero.
`timescale 1ns/1ps
module fpu_fp16_to_int #(
   parameter int INTW       = 32,
   parameter int SHIFT_STEP = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [15:0]            fpuIn,
`ifdef FPU_CVT_RTZ_EN
   input  logic                   rtz,
`endif
   output logic                   outValid,
   input  logic                   outReady,
   output logic signed [INTW-1:0] intOut,
   output logic [1:0]             flags
);

   // Working register must hold the largest finite magnitude (65504) as well as INTW bits.
   localparam int WW = (INTW > 17) ? INTW : 17;
   localparam int MW = WW + 1;
   localparam logic [4:0]      STEP5   = 5'(SHIFT_STEP);
   localparam logic [MW-1:0]   POS_LIM = MW'((64'd1 << (INTW - 1)) - 64'd1);
   localparam logic [MW-1:0]   NEG_LIM = MW'(64'd1 << (INTW - 1));
   localparam logic [INTW-1:0] POS_MAX = {1'b0, {(INTW-1){1'b1}}};
   localparam logic [INTW-1:0] NEG_MIN = {1'b1, {(INTW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
   state_t state, stateNxt;

   logic          sgn, isNan, isInf, shiftLeft, guardBit, stickyBit, truncMode;
   logic [WW-1:0] work;
   logic [4:0]    remain;
   logic          rtzIn;

`ifdef FPU_CVT_RTZ_EN
   assign rtzIn = rtz;
`else
   assign rtzIn = 1'b0;
`endif

   function automatic logic [WW+1:0] shiftStep(input logic [WW-1:0] w, input logic g,
                                               input logic s, input logic left,
                                               input logic [4:0] amt);
      logic [WW-1:0] wv;
      logic          gv, sv;
      wv = w;
      gv = g;
      sv = s;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (5'(i) < amt) begin
            if (left) begin
               wv = {wv[WW-2:0], 1'b0};
            end else begin
               sv = sv | gv;
               gv = wv[0];
               wv = {1'b0, wv[WW-1:1]};
            end
         end
      end
      return {wv, gv, sv};
   endfunction

   function automatic logic [INTW+1:0] roundSat(input logic [WW-1:0] mag, input logic g,
                                                input logic s, input logic neg,
                                                input logic nan, input logic inf,
                                                input logic trunc);
      logic            inc;
      logic [MW-1:0]   rmag;
      logic [INTW-1:0] low;
      logic [INTW-1:0] res;
      logic [1:0]      f;
      inc  = ~trunc & g & (s | mag[0]);
      rmag = {1'b0, mag} + MW'(inc);
      low  = rmag[INTW-1:0];
      if (nan) begin
         res = POS_MAX;
         f   = 2'b10;
      end else if (inf) begin
         res = neg ? NEG_MIN : POS_MAX;
         f   = 2'b10;
      end else if (!neg && rmag > POS_LIM) begin
         res = POS_MAX;
         f   = 2'b10;
      end else if (neg && rmag > NEG_LIM) begin
         res = NEG_MIN;
         f   = 2'b10;
      end else begin
         res = neg ? -low : low;
         f   = {1'b0, g | s};
      end
      return {res, f};
   endfunction

   logic [4:0] expIn, effExp, loadRem, stepAmt;
   logic       loadLeft, loadSpecial;

   assign expIn       = fpuIn[14:10];
   assign effExp      = (expIn == 5'd0) ? 5'd1 : expIn;
   assign loadLeft    = (effExp >= 5'd25);
   assign loadRem     = loadLeft ? (effExp - 5'd25) : (5'd25 - effExp);
   assign loadSpecial = (expIn == 5'h1F);
   assign stepAmt     = (remain > STEP5) ? STEP5 : remain;

   assign inReady  = (state == IDLE);
   assign outValid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:  if (inValid) stateNxt = (loadSpecial || loadRem == 5'd0) ? ROUND : SHIFT;
         SHIFT: if (remain <= STEP5) stateNxt = ROUND;
         ROUND: stateNxt = DONE;
         DONE:  if (outReady) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   // Accept: unpack; align in SHIFT; round/saturate once in ROUND; DONE only holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn       <= 1'b0;
         isNan     <= 1'b0;
         isInf     <= 1'b0;
         shiftLeft <= 1'b0;
         guardBit  <= 1'b0;
         stickyBit <= 1'b0;
         truncMode <= 1'b0;
         work      <= '0;
         remain    <= '0;
         intOut    <= '0;
         flags     <= '0;
      end else begin
         case (state)
            IDLE: if (inValid) begin
               sgn       <= fpuIn[15];
               isNan     <= loadSpecial & (fpuIn[9:0] != 10'd0);
               isInf     <= loadSpecial & (fpuIn[9:0] == 10'd0);
               shiftLeft <= loadLeft;
               guardBit  <= 1'b0;
               stickyBit <= 1'b0;
               truncMode <= rtzIn;
               work      <= {{(WW-11){1'b0}}, (expIn != 5'd0), fpuIn[9:0]};
               remain    <= loadSpecial ? 5'd0 : loadRem;
            end
            SHIFT: begin
               {work, guardBit, stickyBit} <= shiftStep(work, guardBit, stickyBit,
                                                        shiftLeft, stepAmt);
               remain <= remain - stepAmt;
            end
            ROUND: {intOut, flags} <= roundSat(work, guardBit, stickyBit, sgn,
                                               isNan, isInf, truncMode);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Directed bench for fpu_fp16_to_int: a 32-bit instance and an 8-bit instance.
`timescale 1ns/1ps
module tb_fpu_fp16_to_int;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inValid, outReady, inReady, outValid;
   logic [15:0] fpuIn;
   logic [31:0] intOut;
   logic [1:0]  flags;
   logic        inValidB, outReadyB, inReadyB, outValidB;
   logic [15:0] fpuInB;
   logic [7:0]  intOutB;
   logic [1:0]  flagsB;
`ifdef FPU_CVT_RTZ_EN
   logic        rtz  = 1'b0;
   logic        rtzB = 1'b0;
`endif

   int nCmp = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   fpu_fp16_to_int #(.INTW(32), .SHIFT_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .fpuIn(fpuIn),
`ifdef FPU_CVT_RTZ_EN
      .rtz(rtz),
`endif
      .outValid(outValid), .outReady(outReady), .intOut(intOut), .flags(flags));

   fpu_fp16_to_int #(.INTW(8), .SHIFT_STEP(4)) dutB (
      .clk(clk), .rst_n(rst_n), .inValid(inValidB), .inReady(inReadyB), .fpuIn(fpuInB),
`ifdef FPU_CVT_RTZ_EN
      .rtz(rtzB),
`endif
      .outValid(outValidB), .outReady(outReadyB), .intOut(intOutB), .flags(flagsB));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Accept one operand on the 32-bit instance; latency counts the accept cycle as 1.
   task automatic convA(input logic [15:0] v, input logic [31:0] expInt,
                        input logic [1:0] expFlags, input int expLat, input string tag);
      int cyc;
      check({tag, ".rdy"}, 32'(inReady), 32'd1);
      inValid = 1'b1;
      fpuIn   = v;
      @(posedge clk); #1;
      inValid = 1'b0;
      cyc = 1;
      while (!outValid && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".vld"}, 32'(outValid), 32'd1);
      check({tag, ".lat"}, 32'(cyc), 32'(expLat));
      check({tag, ".int"}, intOut, expInt);
      check({tag, ".flg"}, 32'(flags), 32'(expFlags));
   endtask

   task automatic releaseA(input string tag);
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      check({tag, ".idle"}, 32'(inReady), 32'd1);
      check({tag, ".vldLow"}, 32'(outValid), 32'd0);
   endtask

   task automatic convB(input logic [15:0] v, input logic [7:0] expInt,
                        input logic [1:0] expFlags, input int expLat, input string tag);
      int cyc;
      inValidB = 1'b1;
      fpuInB   = v;
      @(posedge clk); #1;
      inValidB = 1'b0;
      cyc = 1;
      while (!outValidB && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".vld"}, 32'(outValidB), 32'd1);
      check({tag, ".lat"}, 32'(cyc), 32'(expLat));
      check({tag, ".int"}, 32'(intOutB), 32'(expInt));
      check({tag, ".flg"}, 32'(flagsB), 32'(expFlags));
      outReadyB = 1'b1;
      @(posedge clk); #1;
      outReadyB = 1'b0;
      check({tag, ".idle"}, 32'(inReadyB), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      inValid = 1'b0; outReady = 1'b0; fpuIn = 16'h0;
      inValidB = 1'b0; outReadyB = 1'b0; fpuInB = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.inReady", 32'(inReady), 32'd1);
      check("rst.outValid", 32'(outValid), 32'd0);
      check("rst.intOut", intOut, 32'd0);
      check("rst.flags", 32'(flags), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      convA(16'h3C00, 32'd1,          2'b00, 5, "one");      releaseA("one");
      convA(16'h3E00, 32'd2,          2'b01, 5, "p1_5");     releaseA("p1_5");
      convA(16'h4100, 32'd2,          2'b01, 5, "p2_5");     releaseA("p2_5");
      convA(16'h4300, 32'd4,          2'b01, 5, "p3_5");     releaseA("p3_5");
      convA(16'hFBFF, 32'hFFFF0020,   2'b00, 4, "maxNeg");   releaseA("maxNeg");
      convA(16'h0001, 32'd0,          2'b01, 8, "denorm");   releaseA("denorm");
      convA(16'h8000, 32'd0,          2'b00, 8, "negZero");  releaseA("negZero");
      convA(16'h6400, 32'd1024,       2'b00, 2, "noShift");  releaseA("noShift");
      convA(16'h7C00, 32'h7FFFFFFF,   2'b10, 2, "posInf");   releaseA("posInf");
      convA(16'hFC00, 32'h80000000,   2'b10, 2, "negInf");   releaseA("negInf");
      convA(16'h7E00, 32'h7FFFFFFF,   2'b10, 2, "nan");      releaseA("nan");

      // Backpressure: result must hold while the consumer stalls.
      convA(16'h4500, 32'd5, 2'b00, 4, "bp");
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("bp.holdInt", intOut, 32'd5);
         check("bp.holdVld", 32'(outValid), 32'd1);
         check("bp.holdRdy", 32'(inReady), 32'd0);
      end
      releaseA("bp");

      // Reset during SHIFT clears outputs without waiting for a clock edge.
      inValid = 1'b1;
      fpuIn   = 16'h3C00;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #2;
      check("midRst.busy", 32'(inReady), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midRst.inReady", 32'(inReady), 32'd1);
      check("midRst.outValid", 32'(outValid), 32'd0);
      check("midRst.intOut", intOut, 32'd0);
      check("midRst.flags", 32'(flags), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      convA(16'hC000, 32'hFFFFFFFE, 2'b00, 5, "negTwo"); releaseA("negTwo");

      convB(16'h5C00, 8'h7F, 2'b10, 3, "b256");
      convB(16'hD800, 8'h80, 2'b00, 3, "bNeg128");
      convB(16'hD810, 8'h80, 2'b10, 3, "bNeg130");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
